// File: rtl/am_pkg.sv
// rtl/am_pkg.sv - shared alignment-marker definitions for the TX PCS lanes
package am_pkg;
    localparam int         AM_PERIOD_DEFAULT = 16384;
    localparam logic [1:0] SYNC_HEAD_CTRL    = 2'b10;
    localparam int         BIP_W             = 8;
    localparam int         LANE_N_DEFAULT    = 4;

    typedef enum logic [1:0] {S_OFF, S_MARK, S_RUN} am_sched_state_t;
endpackage

// File: rtl/am_period_cnt.sv
// rtl/am_period_cnt.sv - loadable wrap counter with terminal-count flag
module am_period_cnt #(
    parameter int W = 14
) (
    input  logic         clk,
    input  logic         nreset,
    input  logic         load_i,
    input  logic [W-1:0] load_val_i,
    input  logic         inc_i,
    input  logic [W-1:0] last_i,
    output logic [W-1:0] cnt_o,
    output logic         tc_o
);
    logic [W-1:0] r_cnt;

    assign tc_o  = (r_cnt == last_i);
    assign cnt_o = r_cnt;

    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            r_cnt <= '0;
        end else if (load_i) begin
            r_cnt <= load_val_i;
        end else if (inc_i) begin
            r_cnt <= tc_o ? '0 : r_cnt + W'(1);
        end
    end
endmodule

// File: rtl/am_insert_sched_tx.sv
// rtl/am_insert_sched_tx.sv - TX alignment-marker slot scheduler for all PCS lanes
// Optional AM_SCHED_CFG_EN adds a runtime period input (cfg_period_i = period-1).
module am_insert_sched_tx
    import am_pkg::*;
#(
    parameter int LANE_N    = LANE_N_DEFAULT,
    parameter int AM_PERIOD = AM_PERIOD_DEFAULT,
    parameter int CNT_W     = 14
) (
    input  logic              clk,
    input  logic              nreset,
    input  logic              en_i,
    input  logic              data_v_i,
    output logic              ready_o,
    output logic [LANE_N-1:0] marker_v_o,
    output logic [CNT_W-1:0]  am_cnt_o,
    output logic              am_sent_o
`ifdef AM_SCHED_CFG_EN
    ,
    input  logic [CNT_W-1:0]  cfg_period_i
`endif
);
    localparam logic [CNT_W-1:0] LP_LAST = CNT_W'(AM_PERIOD - 1);

    am_sched_state_t   r_state;
    logic [LANE_N-1:0] r_marker;
    logic              r_ready;
    logic              r_sent;
    logic              r_dv_q;
    logic              w_inc;
    logic              w_load;
    logic              w_tc;
    logic [CNT_W-1:0]  w_cnt;
    logic [CNT_W-1:0]  w_last;

    // The counter advances in the marker slot and every run slot; anything else parks it at 0.
    assign w_inc  = en_i && (r_state != S_OFF);
    assign w_load = !w_inc;

`ifdef AM_SCHED_CFG_EN
    logic             w_enter_mark;
    logic [CNT_W-1:0] r_last;

    assign w_enter_mark = en_i && ((r_state == S_OFF) || ((r_state == S_RUN) && w_tc));

    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            r_last <= LP_LAST;
        end else if (w_enter_mark) begin
            r_last <= (cfg_period_i == '0) ? CNT_W'(1) : cfg_period_i;
        end
    end

    assign w_last = r_last;
`else
    assign w_last = LP_LAST;
`endif

    am_period_cnt #(.W(CNT_W)) u_period_cnt (
        .clk        (clk),
        .nreset     (nreset),
        .load_i     (w_load),
        .load_val_i ('0),
        .inc_i      (w_inc),
        .last_i     (w_last),
        .cnt_o      (w_cnt),
        .tc_o       (w_tc)
    );

    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            r_state  <= S_OFF;
            r_marker <= '0;
            r_ready  <= 1'b0;
            r_sent   <= 1'b0;
        end else begin
            r_sent <= 1'b0;
            if (!en_i) begin
                r_state  <= S_OFF;
                r_marker <= '0;
                r_ready  <= 1'b0;
            end else begin
                case (r_state)
                    S_OFF: begin
                        r_state  <= S_MARK;
                        r_marker <= '1;
                        r_ready  <= 1'b0;
                    end
                    S_MARK: begin
                        r_state  <= S_RUN;
                        r_marker <= '0;
                        r_ready  <= 1'b1;
                        r_sent   <= 1'b1;
                    end
                    S_RUN: begin
                        if (w_tc) begin
                            r_state  <= S_MARK;
                            r_marker <= '1;
                            r_ready  <= 1'b0;
                        end else begin
                            r_marker <= '0;
                            r_ready  <= 1'b1;
                        end
                    end
                    default: begin
                        r_state  <= S_OFF;
                        r_marker <= '0;
                        r_ready  <= 1'b0;
                    end
                endcase
            end
        end
    end

    // Upstream must hold its block across the marker slot.
    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            r_dv_q <= 1'b0;
        end else begin
            r_dv_q <= data_v_i;
        end
    end

    a_hold_in_marker: assert property (@(posedge clk) disable iff (!nreset)
        ((r_state == S_MARK) && en_i) |-> (data_v_i == r_dv_q));

    assign ready_o    = r_ready;
    assign marker_v_o = r_marker;
    assign am_cnt_o   = w_cnt;
    assign am_sent_o  = r_sent;
endmodule

// File: tb/tb_am_insert_sched_tx.sv
// tb/tb_am_insert_sched_tx.sv - directed self-checking bench for am_insert_sched_tx
module tb_am_insert_sched_tx;
    logic        clk = 1'b0;
    logic        nreset, en, dv;
    logic        ready, sent;
    logic [3:0]  mv;
    logic [13:0] cnt;
    logic        nreset_l, en_l;
    logic        ready_l, sent_l;
    logic [3:0]  mv_l;
    logic [13:0] cnt_l;
`ifdef AM_SCHED_CFG_EN
    logic [13:0] cfg, cfg_l;
`endif
    int checks = 0;
    int passed = 0;

    always #5 clk = ~clk;

    am_insert_sched_tx #(.LANE_N(4), .AM_PERIOD(16), .CNT_W(14)) dut (
        .clk(clk), .nreset(nreset), .en_i(en), .data_v_i(dv),
        .ready_o(ready), .marker_v_o(mv), .am_cnt_o(cnt), .am_sent_o(sent)
`ifdef AM_SCHED_CFG_EN
        , .cfg_period_i(cfg)
`endif
    );

    am_insert_sched_tx #(.LANE_N(4), .AM_PERIOD(16384), .CNT_W(14)) dut_long (
        .clk(clk), .nreset(nreset_l), .en_i(en_l), .data_v_i(dv),
        .ready_o(ready_l), .marker_v_o(mv_l), .am_cnt_o(cnt_l), .am_sent_o(sent_l)
`ifdef AM_SCHED_CFG_EN
        , .cfg_period_i(cfg_l)
`endif
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        nreset = 1'b0; nreset_l = 1'b0; en = 1'b0; en_l = 1'b0; dv = 1'b0;
        repeat (3) step();
        checks++; if ({ready, mv, cnt, sent} !== 20'h0) $display("FAIL reset_in: got %h want 0", {ready, mv, cnt, sent}); else passed++;
        checks++; if ({ready_l, mv_l, cnt_l, sent_l} !== 20'h0) $display("FAIL reset_in_long: got %h want 0", {ready_l, mv_l, cnt_l, sent_l}); else passed++;
        nreset = 1'b1; nreset_l = 1'b1;
        for (int k = 0; k < 100; k++) begin
            step();
            dv = ~dv;
            checks++; if (ready !== 1'b0) $display("FAIL idle_ready: cyc %0d got %b want 0", k, ready); else passed++;
            checks++; if (mv !== 4'h0) $display("FAIL idle_marker: cyc %0d got %h want 0", k, mv); else passed++;
            checks++; if (cnt !== 14'd0) $display("FAIL idle_cnt: cyc %0d got %0d want 0", k, cnt); else passed++;
            checks++; if (sent !== 1'b0) $display("FAIL idle_sent: cyc %0d got %b want 0", k, sent); else passed++;
        end
    endtask

    task automatic test_enable_start();
        logic [3:0]  e_mv;
        logic        e_rdy, e_sent;
        logic [13:0] e_cnt;
        dv = 1'b1;
        en = 1'b1;
        for (int k = 1; k <= 20; k++) begin
            step();
            e_mv   = (k == 1 || k == 17) ? 4'hF : 4'h0;
            e_rdy  = (k >= 2 && k <= 16) || (k >= 18);
            e_sent = (k == 2 || k == 18);
            e_cnt  = (k == 1 || k == 17) ? 14'd0 : (k <= 16) ? 14'(k - 1) : 14'(k - 17);
            checks++; if (mv !== e_mv) $display("FAIL en_marker: k %0d got %h want %h", k, mv, e_mv); else passed++;
            checks++; if (ready !== e_rdy) $display("FAIL en_ready: k %0d got %b want %b", k, ready, e_rdy); else passed++;
            checks++; if (sent !== e_sent) $display("FAIL en_sent: k %0d got %b want %b", k, sent, e_sent); else passed++;
            checks++; if (cnt !== e_cnt) $display("FAIL en_cnt: k %0d got %0d want %0d", k, cnt, e_cnt); else passed++;
        end
    endtask

    task automatic test_abort();
        int found = 0;
        for (int k = 0; k < 40 && found == 0; k++) begin
            step();
            if (mv == 4'hF) found = 1;
        end
        checks++; if (found != 1) $display("FAIL abort_find_marker: got none want marker within 40 cycles"); else passed++;
        en = 1'b0;
        step();
        checks++; if (mv !== 4'h0) $display("FAIL abort_marker: got %h want 0", mv); else passed++;
        checks++; if (ready !== 1'b0) $display("FAIL abort_ready: got %b want 0", ready); else passed++;
        checks++; if (cnt !== 14'd0) $display("FAIL abort_cnt: got %0d want 0", cnt); else passed++;
        checks++; if (sent !== 1'b0) $display("FAIL abort_sent: got %b want 0", sent); else passed++;
        step();
        checks++; if ({sent, mv} !== 5'h0) $display("FAIL abort_hold: got %h want 0", {sent, mv}); else passed++;
        en = 1'b1;
        step();
        checks++; if (mv !== 4'hF) $display("FAIL reen_marker: got %h want f", mv); else passed++;
        checks++; if ({ready, cnt, sent} !== 16'h0) $display("FAIL reen_mark_state: got %h want 0", {ready, cnt, sent}); else passed++;
        step();
        checks++; if ({ready, sent, mv} !== 6'b110000) $display("FAIL reen_run: got %b want 110000", {ready, sent, mv}); else passed++;
        checks++; if (cnt !== 14'd1) $display("FAIL reen_cnt: got %0d want 1", cnt); else passed++;
    endtask

    task automatic test_async_reset();
        int found = 0;
        for (int k = 0; k < 40 && found == 0; k++) begin
            if (cnt == 14'd7) found = 1;
            else step();
        end
        checks++; if (found != 1 || ready !== 1'b1) $display("FAIL arst_reach_cnt7: got cnt %0d ready %b want 7/1", cnt, ready); else passed++;
        #2 nreset = 1'b0;
        #1;
        checks++; if (ready !== 1'b0) $display("FAIL arst_ready: got %b want 0", ready); else passed++;
        checks++; if (cnt !== 14'd0) $display("FAIL arst_cnt: got %0d want 0", cnt); else passed++;
        checks++; if ({mv, sent} !== 5'h0) $display("FAIL arst_marker: got %h want 0", {mv, sent}); else passed++;
        en = 1'b0;
        step();
        nreset = 1'b1;
        step();
        checks++; if ({ready, mv, cnt, sent} !== 20'h0) $display("FAIL arst_after: got %h want 0", {ready, mv, cnt, sent}); else passed++;
        en = 1'b1;
        step();
        checks++; if (mv !== 4'hF) $display("FAIL arst_restart: got %h want f", mv); else passed++;
        en = 1'b0;
        step();
    endtask

    task automatic test_long_run();
        int n_mark = 0, n_sent = 0, last_mark = 0;
        en_l = 1'b1;
        for (int k = 1; k <= 65540; k++) begin
            step();
            if (mv_l != 4'h0) begin
                n_mark++;
                checks++; if (mv_l !== 4'hF) $display("FAIL long_marker_val: k %0d got %h want f", k, mv_l); else passed++;
                if (n_mark == 1) begin
                    checks++; if (k != 1) $display("FAIL long_first: got k %0d want 1", k); else passed++;
                end else begin
                    checks++; if (k - last_mark != 16384) $display("FAIL long_spacing: got %0d want 16384", k - last_mark); else passed++;
                end
                last_mark = k;
            end
            if (sent_l === 1'b1) n_sent++;
            if (k == 16384) begin
                checks++; if (cnt_l !== 14'd16383) $display("FAIL long_cnt_top: got %0d want 16383", cnt_l); else passed++;
            end
        end
        checks++; if (n_mark != 5) $display("FAIL long_markers: got %0d want 5", n_mark); else passed++;
        checks++; if (n_sent != 5) $display("FAIL long_sent: got %0d want 5", n_sent); else passed++;
        en_l = 1'b0;
        step();
    endtask

`ifdef AM_SCHED_CFG_EN
    task automatic test_cfg();
        logic [3:0] e_mv;
        cfg = 14'd15;
        step();
        en = 1'b1;
        for (int k = 1; k <= 30; k++) begin
            step();
            if (k == 5) cfg = 14'd3;
            e_mv = (k == 1 || k == 17 || k == 21 || k == 25 || k == 29) ? 4'hF : 4'h0;
            checks++; if (mv !== e_mv) $display("FAIL cfg_marker: k %0d got %h want %h", k, mv, e_mv); else passed++;
        end
        en = 1'b0;
        cfg = 14'd0;
        step();
        en = 1'b1;
        for (int k = 1; k <= 8; k++) begin
            step();
            e_mv = (k % 2 == 1) ? 4'hF : 4'h0;
            checks++; if (mv !== e_mv) $display("FAIL cfg0_marker: k %0d got %h want %h", k, mv, e_mv); else passed++;
            checks++; if (sent !== (k % 2 == 0)) $display("FAIL cfg0_sent: k %0d got %b want %b", k, sent, (k % 2 == 0)); else passed++;
        end
        en = 1'b0;
        cfg = 14'd15;
        step();
    endtask
`endif

    initial begin
`ifdef AM_SCHED_CFG_EN
        cfg = 14'd15;
        cfg_l = 14'd16383;
`endif
        test_reset();
        test_enable_start();
        test_abort();
        test_async_reset();
`ifdef AM_SCHED_CFG_EN
        test_cfg();
`endif
        test_long_run();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule
